// File: rtl/vga_gen_pkg.sv
// vga_gen_pkg: shared types and constants for the bouncing box pixel source.
package vga_gen_pkg;
  typedef enum logic [1:0] {S_WAIT, S_STEP_X, S_STEP_Y} state_t;
  typedef logic [2:0] colour_idx_t;
  localparam int BORDER_W = 4;
endpackage

// File: rtl/box_axis_step.sv
// box_axis_step: one-axis move of the box by SPEED with edge bounce (dir 1 = increasing).
module box_axis_step #(
  parameter int SPEED = 2
) (
  input  logic [9:0] pos,
  input  logic       dir,
  input  logic [9:0] max,
  output logic [9:0] pos_next,
  output logic       dir_next,
  output logic       bounce
);
  logic [10:0] fwd;
  logic [9:0]  bwd;
  always_comb begin
    fwd      = {1'b0, pos} + 11'(SPEED);
    bwd      = pos - 10'(SPEED);
    bounce   = dir ? (fwd >= {1'b0, max}) : (pos <= 10'(SPEED));
    pos_next = bounce ? (dir ? max : 10'd0) : (dir ? fwd[9:0] : bwd);
    dir_next = bounce ? ~dir : dir;
  end
endmodule

// File: rtl/bouncing_box_gen.sv
// bouncing_box_gen: coloured square bouncing around the visible area, moved once per frame.
// Define BOX_BORDER_EN to add a white frame along the visible edges.
module bouncing_box_gen
  import vga_gen_pkg::*;
#(
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480,
  parameter int BOX_SIZE  = 32,
  parameter int SPEED     = 2,
  parameter int INIT_X    = 100,
  parameter int INIT_Y    = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       iPause,
  input  logic [9:0] iCoord_X,
  input  logic [9:0] iCoord_Y,
  output logic [7:0] oRed,
  output logic [7:0] oGreen,
  output logic [7:0] oBlue,
  output logic       oBounce
);
  localparam logic [9:0] H_MAX = 10'(H_VISIBLE - BOX_SIZE);
  localparam logic [9:0] V_MAX = 10'(V_VISIBLE - BOX_SIZE);
  state_t      state_q, state_d;
  logic [9:0]  box_x_q, box_x_d, box_y_q, box_y_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  colour_idx_t idx_q, idx_d;
  logic        prev_vis_q, prev_vis_d, bounce_q, bounce_d;
  logic [9:0]  nx, ny;
  logic        nx_dir, ny_dir, bx, by;
  logic        vis, tick, step_x, step_y, hit;
  logic        in_vis, in_box, border, white;

  box_axis_step #(.SPEED(SPEED)) u_step_x (
    .pos(box_x_q), .dir(dir_x_q), .max(H_MAX),
    .pos_next(nx), .dir_next(nx_dir), .bounce(bx)
  );
  box_axis_step #(.SPEED(SPEED)) u_step_y (
    .pos(box_y_q), .dir(dir_y_q), .max(V_MAX),
    .pos_next(ny), .dir_next(ny_dir), .bounce(by)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_WAIT;
      box_x_q    <= 10'(INIT_X);
      box_y_q    <= 10'(INIT_Y);
      dir_x_q    <= 1'b1;
      dir_y_q    <= 1'b1;
      idx_q      <= 3'd1;
      prev_vis_q <= 1'b0;
      bounce_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      box_x_q    <= box_x_d;
      box_y_q    <= box_y_d;
      dir_x_q    <= dir_x_d;
      dir_y_q    <= dir_y_d;
      idx_q      <= idx_d;
      prev_vis_q <= prev_vis_d;
      bounce_q   <= bounce_d;
    end
  end

  // One tick per frame, on the first line of vertical blanking
  always_comb begin
    vis     = iCoord_Y < 10'(V_VISIBLE);
    tick    = enable && prev_vis_q && !vis;
    state_d = !enable ? state_q :
              state_q == S_WAIT   ? ((tick && !iPause) ? S_STEP_X : S_WAIT) :
              state_q == S_STEP_X ? S_STEP_Y : S_WAIT;
  end

  always_comb begin
    step_x     = enable && state_q == S_STEP_X;
    step_y     = enable && state_q == S_STEP_Y;
    hit        = (step_x && bx) || (step_y && by);
    prev_vis_d = enable ? vis : prev_vis_q;
    box_x_d    = step_x ? nx : box_x_q;
    dir_x_d    = step_x ? nx_dir : dir_x_q;
    box_y_d    = step_y ? ny : box_y_q;
    dir_y_d    = step_y ? ny_dir : dir_y_q;
    idx_d      = idx_q + {2'b00, hit};
    bounce_d   = enable ? hit : bounce_q;
  end

  always_comb begin
    in_vis = iCoord_X < 10'(H_VISIBLE) && iCoord_Y < 10'(V_VISIBLE);
    in_box = in_vis
          && iCoord_X >= box_x_q && {1'b0, iCoord_X} < {1'b0, box_x_q} + 11'(BOX_SIZE)
          && iCoord_Y >= box_y_q && {1'b0, iCoord_Y} < {1'b0, box_y_q} + 11'(BOX_SIZE);
`ifdef BOX_BORDER_EN
    border = in_vis && (iCoord_X < 10'(BORDER_W) || iCoord_X >= 10'(H_VISIBLE - BORDER_W)
                     || iCoord_Y < 10'(BORDER_W) || iCoord_Y >= 10'(V_VISIBLE - BORDER_W));
`else
    border = 1'b0;
`endif
    white   = border || (in_box && idx_q == 3'd0);
    oRed    = white ? 8'hFF : in_box ? {8{idx_q[2]}} : 8'h00;
    oGreen  = white ? 8'hFF : in_box ? {8{idx_q[1]}} : 8'h00;
    oBlue   = white ? 8'hFF : in_box ? {8{idx_q[0]}} : 8'h00;
    oBounce = bounce_q;
  end
endmodule

// File: tb/tb_bouncing_box_gen.sv
// tb_bouncing_box_gen: scoreboard bench; probes queue expected pixels, a negedge monitor checks them.
module tb_bouncing_box_gen;
  typedef struct {
    int          x;
    int          y;
    logic [23:0] rgb;
    logic        b;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       iPause = 1'b0;
  logic [9:0] iCoord_X = 10'd0;
  logic [9:0] iCoord_Y = 10'd0;
  logic [7:0] oRed, oGreen, oBlue;
  logic       oBounce;
  logic       probe = 1'b0;
  exp_t       sb[$];
  exp_t       e;
  int         checks = 0;
  int         failures = 0;
  int         bx, by, n;
  bit         dx, dy;
  logic [2:0] m_idx;

  bouncing_box_gen dut (
    .clock(clock), .reset(reset), .enable(enable), .iPause(iPause),
    .iCoord_X(iCoord_X), .iCoord_Y(iCoord_Y),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oBounce(oBounce)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (probe) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL scoreboard: probe with no expected entry");
      end else begin
        e = sb.pop_front();
        if ({oRed, oGreen, oBlue} !== e.rgb || oBounce !== e.b) begin
          failures++;
          $display("FAIL pix(%0d,%0d): got rgb=%h bounce=%b, expected rgb=%h bounce=%b",
                   e.x, e.y, {oRed, oGreen, oBlue}, oBounce, e.rgb, e.b);
        end
      end
    end
  end

  function automatic logic [23:0] exp_rgb(input int x, input int y);
    if (x >= 640 || y >= 480) return 24'h000000;
`ifdef BOX_BORDER_EN
    if (x < 4 || x >= 636 || y < 4 || y >= 476) return 24'hFFFFFF;
`endif
    if (!(x >= bx && x < bx + 32 && y >= by && y < by + 32)) return 24'h000000;
    if (m_idx == 3'd0) return 24'hFFFFFF;
    return {{8{m_idx[2]}}, {8{m_idx[1]}}, {8{m_idx[0]}}};
  endfunction

  task automatic model_reset();
    bx = 100; by = 50; dx = 1; dy = 1; m_idx = 3'd1;
  endtask

  task automatic model_axis(inout int p, inout bit d, input int mx, output bit b);
    b = 0;
    if (d && p + 2 >= mx) begin p = mx; d = 0; b = 1; end
    else if (!d && p <= 2) begin p = 0; d = 1; b = 1; end
    else p = d ? p + 2 : p - 2;
    m_idx = m_idx + {2'b00, b};
  endtask

  task automatic probe_px(input int x, input int y, input logic [23:0] rgb, input logic b);
    iCoord_X = 10'(x);
    iCoord_Y = 10'(y);
    sb.push_back('{x, y, rgb, b});
    probe = 1'b1;
    @(negedge clock);
    #1 probe = 1'b0;
  endtask

  task automatic en_cycle(input int y);
    iCoord_Y = 10'(y);
    enable = 1'b1;
    @(posedge clock);
    #1 enable = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // pause: iPause high at the tick; mid: iPause high only during the step cycles
  task automatic frame(input bit pause, input bit mid);
    bit b1, b2;
    b1 = 0; b2 = 0;
    en_cycle(479);
    iPause = pause;
    en_cycle(480);
    iPause = mid;
    en_cycle(480);
    if (!pause) model_axis(bx, dx, 608, b1);
    probe_px(bx, by, exp_rgb(bx, by), b1);
    en_cycle(480);
    if (!pause) begin model_axis(by, dy, 448, b2); n++; end
    probe_px(bx + 32, by + 31, exp_rgb(bx + 32, by + 31), b2);
    iPause = 1'b0;
  endtask

  initial begin
    model_reset();
    n = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    probe_px(100, 50, 24'h0000FF, 1'b0);
    probe_px(132, 50, 24'h000000, 1'b0);
    probe_px(99, 81, 24'h000000, 1'b0);
    probe_px(131, 81, 24'h0000FF, 1'b0);
    probe_px(700, 10, 24'h000000, 1'b0);
    probe_px(100, 500, 24'h000000, 1'b0);
`ifdef BOX_BORDER_EN
    probe_px(0, 0, 24'hFFFFFF, 1'b0);
    probe_px(639, 479, 24'hFFFFFF, 1'b0);
`else
    probe_px(0, 0, 24'h000000, 1'b0);
    probe_px(639, 479, 24'h000000, 1'b0);
`endif
    frame(0, 0);
    probe_px(101, 51, 24'h000000, 1'b0);
    probe_px(102, 52, 24'h0000FF, 1'b0);
    repeat (3) frame(1, 0);
    probe_px(102, 52, 24'h0000FF, 1'b0);
    probe_px(133, 83, 24'h0000FF, 1'b0);
    probe_px(134, 52, 24'h000000, 1'b0);
    frame(0, 1);
    probe_px(104, 54, 24'h0000FF, 1'b0);
    probe_px(103, 54, 24'h000000, 1'b0);
    // reset while the FSM sits in S_STEP_X
    en_cycle(479);
    en_cycle(480);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
    n = 0;
    probe_px(100, 50, 24'h0000FF, 1'b0);
    probe_px(131, 81, 24'h0000FF, 1'b0);
    probe_px(132, 81, 24'h000000, 1'b0);
    en_cycle(480);
    en_cycle(480);
    probe_px(100, 50, 24'h0000FF, 1'b0);
    probe_px(102, 82, 24'h000000, 1'b0);
    while (n < 880) frame(0, 0);
    // y bounces at moves 199,423,647,871; x at 254,558,862 -> idx wraps to 0 (white)
    probe_px(572, 18, 24'hFFFFFF, 1'b0);
    probe_px(571, 18, 24'h000000, 1'b0);
    probe_px(603, 49, 24'hFFFFFF, 1'b0);
    probe_px(604, 49, 24'h000000, 1'b0);
    probe_px(572, 50, 24'h000000, 1'b0);
    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
